// File: rtl/seq_signed_divider.sv
// Iterative signed divider: a 2N-bit dividend divided by an N-bit divisor.
// The quotient truncates toward zero and the remainder takes the dividend's
// sign. A restoring shift/subtract loop on the operand magnitudes runs for
// exactly 2N cycles, with a start/busy/done handshake. The quotient output is
// the low N bits of the signed 2N-bit quotient, so it wraps when overflow is set.
module seq_signed_divider #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           overflow,
   output logic           div_zero
);

   localparam int CW = $clog2(2*N);
   localparam logic [CW-1:0] LAST_ITER = CW'(2*N-1);
   // 2^(N-1): the largest quotient magnitude that can still be negative.
   localparam logic [2*N-1:0] QLIM = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

   state_t         state_reg, state_next;
   logic           sd_reg, sd_next;      // dividend sign
   logic           sv_reg, sv_next;      // divisor sign
   // Unsigned dividend magnitude. 2^(2N-1) fits in 2N unsigned bits, and the
   // loop shifts bits out at the top.
   logic [2*N-1:0] dvd_reg, dvd_next;
   logic [N:0]     dvs_reg, dvs_next;    // divisor magnitude (holds 2^(N-1))
   logic [N:0]     rem_reg, rem_next;    // partial remainder
   logic [2*N-1:0] quo_reg, quo_next;    // unsigned quotient magnitude
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           done_reg, done_next;
   logic [N-1:0]   quotient_reg, quotient_next;
   logic [N-1:0]   remainder_reg, remainder_next;
   logic           overflow_reg, overflow_next;
   logic           div_zero_reg, div_zero_next;

   // Datapath helpers
   logic [2*N-1:0] dvd_abs;
   logic [N:0]     dvs_ext, dvs_abs;
   logic [N:0]     rem_shift;
   logic [N+1:0]   trial;
   logic [2*N-1:0] q_signed;
   logic [N:0]     r_signed;
   logic           q_neg, q_ovf, dz;
   logic           unused_bits;

   assign dvd_abs   = dividend[2*N-1] ? -dividend : dividend;
   assign dvs_ext   = {divisor[N-1], divisor};
   assign dvs_abs   = divisor[N-1] ? -dvs_ext : dvs_ext;
   // The remainder stays below |divisor| <= 2^(N-1), so its top bit is always
   // clear and dropping it in the shift loses nothing.
   assign rem_shift = {rem_reg[N-1:0], dvd_reg[2*N-1]};
   assign trial     = {1'b0, rem_shift} - {1'b0, dvs_reg};
   assign q_neg     = sd_reg ^ sv_reg;
   assign q_signed  = q_neg ? -quo_reg : quo_reg;
   assign r_signed  = sd_reg ? -rem_reg : rem_reg;
   assign q_ovf     = q_neg ? (quo_reg > QLIM) : (quo_reg >= QLIM);
   assign dz        = (dvs_reg == '0);
   assign unused_bits = ^{rem_reg[N], r_signed[N], q_signed[2*N-1:N]};

   // Register all state, with an asynchronous return to the reset values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         sd_reg        <= 1'b0;
         sv_reg        <= 1'b0;
         dvd_reg       <= '0;
         dvs_reg       <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         cnt_reg       <= '0;
         done_reg      <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         overflow_reg  <= 1'b0;
         div_zero_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sd_reg        <= sd_next;
         sv_reg        <= sv_next;
         dvd_reg       <= dvd_next;
         dvs_reg       <= dvs_next;
         rem_reg       <= rem_next;
         quo_reg       <= quo_next;
         cnt_reg       <= cnt_next;
         done_reg      <= done_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         overflow_reg  <= overflow_next;
         div_zero_reg  <= div_zero_next;
      end
   end

   // Next-state logic: accept the operands, iterate once per cycle, then sign-fix the result.
   always_comb begin
      state_next     = state_reg;
      sd_next        = sd_reg;
      sv_next        = sv_reg;
      dvd_next       = dvd_reg;
      dvs_next       = dvs_reg;
      rem_next       = rem_reg;
      quo_next       = quo_reg;
      cnt_next       = cnt_reg;
      done_next      = 1'b0;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      overflow_next  = overflow_reg;
      div_zero_next  = div_zero_reg;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               sd_next    = dividend[2*N-1];
               sv_next    = divisor[N-1];
               dvd_next   = dvd_abs;
               dvs_next   = dvs_abs;
               rem_next   = '0;
               quo_next   = '0;
               cnt_next   = '0;
               state_next = DIV;
            end
         end
         DIV: begin
            dvd_next = {dvd_reg[2*N-2:0], 1'b0};
            quo_next = {quo_reg[2*N-2:0], ~trial[N+1]};
            rem_next = trial[N+1] ? rem_shift : trial[N:0];
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == LAST_ITER) begin
               state_next = FIN;
            end
         end
         FIN: begin
            if (dz) begin
               quotient_next  = '0;
               remainder_next = '0;
               overflow_next  = 1'b0;
            end else begin
               quotient_next  = q_signed[N-1:0];
               remainder_next = r_signed[N-1:0];
               overflow_next  = q_ovf;
            end
            div_zero_next = dz;
            done_next     = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign overflow  = overflow_reg;
   assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider (N=8): directed cases, handshake corners,
// mid-operation reset, and randomized operands compared with a truncating
// division model through an expected-result queue.
module tb_seq_signed_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy, done, overflow, div_zero;
   logic [7:0]  quotient, remainder;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       ovf;
      logic       dz;
      int         dvd;
      int         dvs;
   } exp_t;

   exp_t sb[$];
   int   total    = 0;
   int   pass_cnt = 0;

   seq_signed_divider #(.N(8)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .overflow(overflow), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input int a, input int b);
      exp_t e;
      int   qt;
      int   rt;
      e.dvd = a;
      e.dvs = b;
      if (b == 0) begin
         e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b0; e.dz = 1'b1;
      end else begin
         qt    = a / b;
         rt    = a % b;
         e.q   = qt[7:0];
         e.r   = rt[7:0];
         e.ovf = (qt > 127) || (qt < -128);
         e.dz  = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Queue the expected result, pulse start for one cycle; returns just after the accepting edge.
   task automatic start_op(input int a, input int b);
      sb.push_back(model(a, b));
      dividend = a[15:0];
      divisor  = b[7:0];
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   // Wait for done, bounded; lat counts rising edges since the accepting edge.
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic compare();
      exp_t e;
      int   qi;
      int   ri;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("quotient",  {24'd0, quotient},  {24'd0, e.q});
      check("remainder", {24'd0, remainder}, {24'd0, e.r});
      check("overflow",  {31'd0, overflow},  {31'd0, e.ovf});
      check("div_zero",  {31'd0, div_zero},  {31'd0, e.dz});
      if (!e.ovf && !e.dz) begin
         qi = $signed(quotient);
         ri = $signed(remainder);
         check("q_times_d_plus_r", qi * e.dvs + ri, e.dvd);
      end
      $display("op %0d / %0d -> q=%02h r=%02h ovf=%0b dz=%0b", e.dvd, e.dvs,
               quotient, remainder, overflow, div_zero);
   endtask

   task automatic finish_op();
      int lat;
      wait_done(0, lat);
      check("latency", lat, 17);
      compare();
   endtask

   initial begin
      int   lat;
      int   lat2;
      bit   saw_done;
      logic [7:0]  b8;
      logic [15:0] a16;
      logic [10:0] a11;
      int   ai;
      int   bi;

      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_quotient", {24'd0, quotient}, 32'd0);
      check("rst_remainder", {24'd0, remainder}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_div_zero", {31'd0, div_zero}, 32'd0);

      // Directed values, including the overflow and divide-by-zero corners.
      start_op(1000, 8);       finish_op();
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("quotient_holds", {24'd0, quotient}, 32'h7D);
      start_op(-100, 7);       finish_op();
      start_op(1000, -9);      finish_op();
      start_op(-32768, -1);    finish_op();
      start_op(32767, 127);    finish_op();
      start_op(-32768, -128);  finish_op();
      start_op(32'h1234, 0);   finish_op();
      start_op(-32768, 1);     finish_op();
      start_op(-128, 1);       finish_op();

      // Start and operand changes during busy are ignored.
      start_op(500, 3);
      repeat (5) @(negedge clk);
      dividend = 16'd7; divisor = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, lat);
      check("latency_ignored_start", lat, 17);
      compare();
      @(negedge clk);
      check("no_second_op", {31'd0, busy}, 32'd0);

      // Start on the done cycle is accepted back-to-back.
      start_op(-1234, 10);
      wait_done(0, lat);
      check("latency_b2b_first", lat, 17);
      compare();
      sb.push_back(model(777, -5));
      dividend = 16'd777; divisor = 8'hFB; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_done_cleared", {31'd0, done}, 32'd0);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      wait_done(0, lat2);
      check("b2b_spacing", lat2 + 1, 18);
      compare();

      // Reset partway through an operation aborts it without a done pulse.
      start_op(-3000, 7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_quotient", {24'd0, quotient}, 32'd0);
      check("abort_remainder", {24'd0, remainder}, 32'd0);
      check("abort_overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      void'(sb.pop_back());
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
      start_op(-3000, 7);      finish_op();

      // Randomized operands; odd steps use small dividends so most quotients fit.
      for (int i = 0; i < 1000; i++) begin
         b8  = 8'($urandom);
         a16 = 16'($urandom);
         a11 = 11'($urandom);
         bi  = $signed(b8);
         if (i % 2 == 1) ai = $signed(a11);
         else            ai = $signed(a16);
         start_op(ai, bi);
         finish_op();
      end

      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
